// File: rtl/stage1_driver.sv
// stage1_driver: runs a fixed number of rounds against an external
// combinational stage-1 checker. Each round drives LFSR-derived vectors
// and then scores the checker's response. All outputs are registered.
module stage1_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] seed,
    input  logic [3:0] rounds,
    input  logic       weather_in,
    input  logic       pass1,
    input  logic [1:0] bonus1,
    output logic [6:0] speed,
    output logic [6:0] random1,
    output logic [1:0] breakfast,
    output logic [1:0] movement,
    output logic       weather,
    output logic       busy,
    output logic       done,
    output logic [5:0] score,
    output logic [3:0] fail_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t     state;
    logic [6:0] lfsr;
    logic [3:0] round_cnt;
    logic       wx_lat;

    // Score increment is computed one bit wider so saturation is a simple compare.
    logic [6:0] score_sum;
    assign score_sum = {1'b0, score} + {5'b0, bonus1} + 7'd1;

    // Round sequencer: driven vectors are registered when leaving DRIVE, so
    // they are stable for the whole SAMPLE cycle in which pass1/bonus1 are taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= '0;
            round_cnt <= '0;
            wx_lat    <= 1'b0;
            score     <= '0;
            fail_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            speed     <= '0;
            random1   <= '0;
            breakfast <= '0;
            movement  <= '0;
            weather   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // An all-zero LFSR would lock up, so seed 0 maps to 1.
                        lfsr      <= (seed == 7'd0) ? 7'h01 : seed;
                        round_cnt <= '0;
                        score     <= '0;
                        fail_cnt  <= '0;
                        wx_lat    <= weather_in;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    random1   <= lfsr;
                    speed     <= {lfsr[2:0], lfsr[6:3]};
                    breakfast <= lfsr[6:5];
                    movement  <= lfsr[1:0] ^ round_cnt[1:0];
                    weather   <= wx_lat;
                    state     <= SAMPLE;
                end
                SAMPLE: begin
                    if (pass1) begin
                        score <= (score_sum > 7'd63) ? 6'd63 : score_sum[5:0];
                    end else if (fail_cnt != 4'd15) begin
                        fail_cnt <= fail_cnt + 4'd1;
                    end
                    lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    // rounds-1 wraps to 15 for rounds=0, giving 16 rounds.
                    if (round_cnt == rounds - 4'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                        state     <= DRIVE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    speed     <= '0;
                    random1   <= '0;
                    breakfast <= '0;
                    movement  <= '0;
                    weather   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_driver.sv
// Scoreboard bench for stage1_driver: a reference model queues the expected
// per-round vectors and final results; a monitor compares what the DUT shows.
module tb_stage1_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] seed;
    logic [3:0] rounds;
    logic       weather_in;
    logic       pass1;
    logic [1:0] bonus1;
    logic [6:0] speed, random1;
    logic [1:0] breakfast, movement;
    logic       weather, busy, done;
    logic [5:0] score;
    logic [3:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    // Checker behaviour: 0 = pseudo-random function of random1, 1 = always
    // pass with bonus 3, 2 = always fail.
    int ck_mode = 0;

    typedef struct {
        int rnd, spd, brk, mov, wx;
    } drv_t;
    typedef struct {
        int n, sc, fc;
    } res_t;

    drv_t drv_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    stage1_driver dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .rounds(rounds),
        .weather_in(weather_in), .pass1(pass1), .bonus1(bonus1),
        .speed(speed), .random1(random1), .breakfast(breakfast),
        .movement(movement), .weather(weather), .busy(busy), .done(done),
        .score(score), .fail_cnt(fail_cnt)
    );

    function automatic int ck_pass(input int v, input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return 0;
        return ((v >> 1) ^ (v >> 4) ^ v) & 1;
    endfunction

    function automatic int ck_bonus(input int v, input int mode);
        if (mode == 1) return 3;
        if (mode == 2) return 0;
        return ((v >> 2) ^ (v >> 5)) & 3;
    endfunction

    // Combinational stand-in for the stage-1 checker.
    always_comb begin
        pass1  = ck_pass(int'(random1), ck_mode) != 0;
        bonus1 = 2'(ck_bonus(int'(random1), ck_mode));
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: walks the whole run with plain integer arithmetic.
    task automatic model(input int sd, input int rn, input int wx, input int mode,
                         output int fsc, output int ffc);
        int l, n, sc, fc;
        drv_t d;
        res_t r;
        l  = (sd == 0) ? 1 : sd;
        n  = (rn == 0) ? 16 : rn;
        sc = 0;
        fc = 0;
        for (int i = 0; i < n; i++) begin
            d.rnd = l;
            d.spd = ((l << 4) | (l >> 3)) & 127;
            d.brk = l / 32;
            d.mov = (l % 4) ^ (i % 4);
            d.wx  = wx;
            drv_q.push_back(d);
            if (ck_pass(l, mode) != 0) sc = (sc + ck_bonus(l, mode) + 1 > 63) ? 63 : sc + ck_bonus(l, mode) + 1;
            else fc = (fc + 1 > 15) ? 15 : fc + 1;
            l = ((l << 1) | (((l >> 6) ^ (l >> 5)) & 1)) & 127;
        end
        r.n = n; r.sc = sc; r.fc = fc;
        res_q.push_back(r);
        fsc = sc;
        ffc = fc;
    endtask

    // Monitor: k counts cycles since busy rose (0 = DRIVE). Odd k is SAMPLE,
    // where the round's vectors must be visible; done must land at k = 2N.
    int  k = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        drv_t d;
        res_t r;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) k = 0;
            else if (busy) k++;
            prev_busy = busy;
            if (busy && (k % 2 == 1) && !done) begin
                if (drv_q.size() == 0) begin
                    check("unexpected_round", k, -1);
                end else begin
                    d = drv_q.pop_front();
                    check("random1", int'(random1), d.rnd);
                    check("speed", int'(speed), d.spd);
                    check("breakfast", int'(breakfast), d.brk);
                    check("movement", int'(movement), d.mov);
                    check("weather", int'(weather), d.wx);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("done_latency", k, 2 * r.n);
                    check("score", int'(score), r.sc);
                    check("fail_cnt", int'(fail_cnt), r.fc);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_speed0"}, int'(speed), 0);
        check({tag, "_random0"}, int'(random1), 0);
        check({tag, "_brk0"}, int'(breakfast), 0);
        check({tag, "_mov0"}, int'(movement), 0);
        check({tag, "_wx0"}, int'(weather), 0);
        check({tag, "_busy0"}, int'(busy), 0);
    endtask

    // One complete run; mid_start pulses start (with another seed) during round 2.
    task automatic run(input int sd, input int rn, input int wx, input int mode,
                       input bit mid_start);
        int fsc, ffc, n;
        bit got;
        ck_mode = mode;
        model(sd, rn, wx, mode, fsc, ffc);
        n = (rn == 0) ? 16 : rn;
        @(posedge clk); #1;
        seed = 7'(sd); rounds = 4'(rn); weather_in = wx[0]; start = 1'b1;
        @(posedge clk); #1;           // edge 0: start accepted
        start = 1'b0;
        weather_in = ~weather_in;
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1;
            seed = 7'(sd ^ 7'h35); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 2 * n + 8; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            drv_q.delete();
            res_q.delete();
        end
        @(posedge clk); #1;
        check_idle_outputs("post_done");
        check("hold_score", int'(score), fsc);
        check("hold_fail", int'(fail_cnt), ffc);
        repeat (2) @(posedge clk);
        #1;
        check("idle_score", int'(score), fsc);
        check("idle_done", int'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed = '0; rounds = '0; weather_in = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset_score", int'(score), 0);
        check("reset_fail", int'(fail_cnt), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 1, 0, 0, 1'b0);          // seed 0 -> lfsr 1, single round
        run(5, 4, 1, 1, 1'b0);          // all pass, bonus 3 -> 16
        run(77, 0, 0, 1, 1'b0);         // 16 rounds, score saturates
        run(99, 0, 1, 2, 1'b0);         // 16 fails, fail_cnt saturates
        run(23, 4, 1, 0, 1'b1);         // start mid-run ignored
        for (int i = 0; i < 6; i++)
            run(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);

        // Abort during SAMPLE of round 3 (k = 5).
        ck_mode = 0;
        @(posedge clk); #1;
        seed = 7'h11; rounds = 4'd4; weather_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int f1, f2;
            model(7'h11, 4, 1, 0, f1, f2);
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        drv_q.delete();
        res_q.delete();
        check_idle_outputs("abort");
        check("abort_score", int'(score), 0);
        check("abort_fail", int'(fail_cnt), 0);
        check("abort_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_restart", int'(busy), 0);
        run(1, 1, 0, 0, 1'b0);          // reproduces the seed-0 run

        repeat (3) @(posedge clk);
        check("queue_drained", drv_q.size() + res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
